// File: rtl/jtcps1_obj_line_scan.sv
// OBJ line scanner: walks the frozen OBJ table for line vrender and issues one
// drawer request per 16-pixel tile column of every sprite covering that line.
// Optional per-line draw limit: define JTCPS1_OBJ_LIMIT_EN (uses MAXDRAW).
//
// Drawer handshake: dr_start is a 1-clk pulse and the dr_* fields are valid
// with it and hold until the next pulse. No pulse is issued while dr_busy is
// high, and consecutive pulses are at least 2 clk apart so the drawer has one
// clk to raise dr_busy.
module jtcps1_obj_line_scan #(
  parameter int MAXDRAW = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [8:0]  vrender,
  output logic [9:0]  table_addr,
  input  logic [15:0] table_data,
  output logic        dr_start,
  input  logic        dr_busy,
  output logic [15:0] dr_code,
  output logic [15:0] dr_attr,
  output logic [8:0]  dr_hpos,
  output logic [3:0]  dr_vsub,
  output logic        done,
  output logic        overflow
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_RD_ATTR, ST_RD_X, ST_RD_Y, ST_RD_CODE, ST_CHECK, ST_EMIT, ST_DONE
  } state_t;

  state_t      state, state_nx;
  logic        rd_ph;
  logic [7:0]  entry;
  logic [8:0]  vr;
  logic [8:0]  obj_x;
  logic [8:0]  obj_y;
  logic [15:0] obj_code;
  logic [15:0] obj_attr;
  logic [3:0]  row;
  logic [3:0]  vsub;
  logic [3:0]  col;
  logic        gap;
  logic        issue;
  logic        limit_hit;

  logic [3:0]  h, w, tc;
  logic        vflip, hflip;
  logic [8:0]  dy;
  logic [4:0]  rows;
  logic        hit;
  logic        last_entry;
  logic        end_mark;
  logic [7:0]  next_entry;
  logic [15:0] code_nx;
  logic [8:0]  hpos_nx;

  assign h          = obj_attr[15:12];
  assign w          = obj_attr[11:8];
  assign vflip      = obj_attr[6];
  assign hflip      = obj_attr[5];
  assign dy         = vr - obj_y;
  assign rows       = {1'b0, h} + 5'd1;
  assign hit        = dy < {rows, 4'd0};
  assign last_entry = &entry;
  assign end_mark   = table_data[15:8] == 8'hFF;
  assign next_entry = entry + 8'd1;
  assign tc         = hflip ? w - col : col;
  // Low nibble wraps inside the tile group; the row offset carries upward.
  assign code_nx    = {obj_code[15:4], 4'd0} + {8'd0, row, 4'd0}
                    + {12'd0, obj_code[3:0] + tc};
  assign hpos_nx    = obj_x + {1'b0, col, 4'd0};

`ifdef JTCPS1_OBJ_LIMIT_EN
  localparam int CW = $clog2(MAXDRAW + 1);
  logic [CW-1:0] draw_cnt;

  assign limit_hit = draw_cnt == CW'(MAXDRAW - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      draw_cnt <= '0;
    end else if (start) begin
      draw_cnt <= '0;
    end else if (issue) begin
      draw_cnt <= draw_cnt + CW'(1);
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^MAXDRAW;
  assign limit_hit  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    case (state)
      ST_IDLE:    state_nx = ST_IDLE;
      ST_RD_ATTR: if (rd_ph) state_nx = end_mark ? ST_DONE : ST_RD_X;
      ST_RD_X:    if (rd_ph) state_nx = ST_RD_Y;
      ST_RD_Y:    if (rd_ph) state_nx = ST_RD_CODE;
      ST_RD_CODE: if (rd_ph) state_nx = ST_CHECK;
      ST_CHECK: begin
        if (hit)             state_nx = ST_EMIT;
        else if (last_entry) state_nx = ST_DONE;
        else                 state_nx = ST_RD_ATTR;
      end
      ST_EMIT: begin
        if (!gap && !dr_busy) begin
          issue = 1'b1;
          if (limit_hit)       state_nx = ST_DONE;
          else if (col == w)   state_nx = last_entry ? ST_DONE : ST_RD_ATTR;
        end
      end
      ST_DONE:    state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
    // A new line always wins, including over a draw about to be issued.
    if (start) begin
      state_nx = ST_RD_ATTR;
      issue    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ph      <= 1'b0;
      entry      <= 8'd0;
      vr         <= 9'd0;
      obj_x      <= 9'd0;
      obj_y      <= 9'd0;
      obj_code   <= 16'd0;
      obj_attr   <= 16'd0;
      row        <= 4'd0;
      vsub       <= 4'd0;
      col        <= 4'd0;
      gap        <= 1'b0;
      table_addr <= 10'd0;
      dr_start   <= 1'b0;
      dr_code    <= 16'd0;
      dr_attr    <= 16'd0;
      dr_hpos    <= 9'd0;
      dr_vsub    <= 4'd0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      dr_start <= issue;
      gap      <= issue;
      if (issue) begin
        dr_code <= code_nx;
        dr_hpos <= hpos_nx;
        dr_vsub <= vsub;
        dr_attr <= obj_attr;
        col     <= col + 4'd1;
        if (limit_hit) overflow <= 1'b1;
      end
      if (state_nx == ST_DONE) done <= 1'b1;
      if (start) begin
        entry      <= 8'd0;
        vr         <= vrender;
        done       <= 1'b0;
        overflow   <= 1'b0;
        rd_ph      <= 1'b0;
        table_addr <= 10'h003;
      end else begin
        case (state)
          ST_RD_ATTR: begin
            rd_ph <= ~rd_ph;
            if (rd_ph) begin
              obj_attr <= table_data;
              if (!end_mark) table_addr <= {entry, 2'd0};
            end
          end
          ST_RD_X: begin
            rd_ph <= ~rd_ph;
            if (rd_ph) begin
              obj_x      <= table_data[8:0];
              table_addr <= {entry, 2'd1};
            end
          end
          ST_RD_Y: begin
            rd_ph <= ~rd_ph;
            if (rd_ph) begin
              obj_y      <= table_data[8:0];
              table_addr <= {entry, 2'd2};
            end
          end
          ST_RD_CODE: begin
            rd_ph <= ~rd_ph;
            if (rd_ph) obj_code <= table_data;
          end
          ST_CHECK: begin
            if (hit) begin
              col  <= 4'd0;
              row  <= vflip ? h - dy[7:4] : dy[7:4];
              vsub <= dy[3:0] ^ {4{vflip}};
            end
          end
          default: ;
        endcase
        if ((state == ST_CHECK || state == ST_EMIT) && state_nx == ST_RD_ATTR) begin
          entry      <= next_entry;
          table_addr <= {next_entry, 2'd3};
        end
      end
    end
  end

endmodule

// File: tb/tb_jtcps1_obj_line_scan.sv
// Bench for jtcps1_obj_line_scan: table RAM and drawer models, a behavioural
// line model feeding an expected queue, and directed scenarios.
module tb_jtcps1_obj_line_scan;

  localparam int MAXDRAW = 32;
  localparam int W = 45;  // {code, hpos, vsub, attr}

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  vrender;
  logic [9:0]  table_addr;
  logic [15:0] table_data;
  logic        dr_start;
  logic        dr_busy;
  logic [15:0] dr_code;
  logic [15:0] dr_attr;
  logic [8:0]  dr_hpos;
  logic [3:0]  dr_vsub;
  logic        done;
  logic        overflow;

  jtcps1_obj_line_scan #(.MAXDRAW(MAXDRAW)) dut (
    .clk(clk), .rst(rst), .start(start), .vrender(vrender),
    .table_addr(table_addr), .table_data(table_data),
    .dr_start(dr_start), .dr_busy(dr_busy), .dr_code(dr_code),
    .dr_attr(dr_attr), .dr_hpos(dr_hpos), .dr_vsub(dr_vsub),
    .done(done), .overflow(overflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // table RAM: data one clk after address
  logic [15:0] tbl [0:1023];
  always @(posedge clk) table_data <= tbl[table_addr];

  // drawer: busy for busy_len clk after each request, or forced high
  int   busy_len = 3;
  int   busy_cnt = 0;
  logic force_busy = 1'b0;
  always @(posedge clk) begin
    #1;
    if (force_busy) dr_busy = 1'b1;
    else if (dr_start) begin
      busy_cnt = busy_len;
      dr_busy  = (busy_len != 0);
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      dr_busy = (busy_cnt != 0);
    end else dr_busy = 1'b0;
  end

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic         exp_ovf;
  logic         busy_seen = 1'b0;
  logic         prev_start = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(posedge clk) busy_seen = dr_busy;

  always @(negedge clk) begin
    logic [W-1:0] got, e;
    if (!rst && dr_start) begin
      got = {dr_code, dr_hpos, dr_vsub, dr_attr};
      got_q.push_back(got);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_draw: got %0h expected none", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL draw_fields: got %0h expected %0h", got, e);
        end
      end
      chk("draw_handshake", {busy_seen, prev_start}, 2'b00);
    end
    prev_start = dr_start;
  end

  // line model: what the drawer must receive for line vr
  task automatic build_model(input logic [8:0] vr);
    int draws;
    exp_q.delete();
    exp_ovf = 1'b0;
    draws = 0;
    for (int e = 0; e < 256; e++) begin
      int x, y, code, attr, h, w, dy, row, vs;
      logic vf, hf;
      attr = tbl[e*4+3];
      if ((attr >> 8) == 'hFF) break;
      x    = tbl[e*4];
      y    = tbl[e*4+1] & 511;
      code = tbl[e*4+2];
      h    = (attr >> 12) & 15;
      w    = (attr >> 8) & 15;
      vf   = attr[6];
      hf   = attr[5];
      dy   = (int'(vr) - y) & 511;
      if (dy < (h + 1) * 16) begin
        row = vf ? h - dy / 16 : dy / 16;
        vs  = vf ? 15 - dy % 16 : dy % 16;
        for (int c = 0; c <= w; c++) begin
          int tc, cd, hp;
          tc = hf ? w - c : c;
          cd = ((code & 'hFFF0) + row * 16 + (((code & 15) + tc) & 15)) & 'hFFFF;
          hp = (x + c * 16) & 511;
          exp_q.push_back({cd[15:0], hp[8:0], vs[3:0], attr[15:0]});
          draws++;
`ifdef JTCPS1_OBJ_LIMIT_EN
          if (draws == MAXDRAW) begin
            exp_ovf = 1'b1;
            break;
          end
`endif
        end
      end
      if (exp_ovf) break;
    end
  endtask

  // driver tasks
  task automatic clear_tbl();
    for (int i = 0; i < 1024; i++) tbl[i] = 16'd0;
  endtask

  task automatic set_entry(input int e, input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] code, input logic [15:0] attr);
    tbl[e*4]   = x;
    tbl[e*4+1] = y;
    tbl[e*4+2] = code;
    tbl[e*4+3] = attr;
  endtask

  task automatic pulse_start(input logic [8:0] vr);
    @(negedge clk);
    vrender = vr;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    vrender = 9'h1AB;  // must not matter after the sampling edge
  endtask

  task automatic wait_done(input string name, input int bound);
    int n;
    n = 0;
    while (!done && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, done, 1);
    @(negedge clk);
    #1;
  endtask

  task automatic run_scan(input string name, input logic [8:0] vr, input int bound);
    got_q.delete();
    build_model(vr);
    pulse_start(vr);
    wait_done(name, bound);
    chk({name, "_pending"}, exp_q.size(), 0);
    chk({name, "_overflow"}, overflow, exp_ovf);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; vrender = 9'd0; dr_busy = 1'b0;
    clear_tbl();
    repeat (3) @(negedge clk);
    chk("reset_table_addr", table_addr, 0);
    chk("reset_done", done, 0);
    chk("reset_dr_start", dr_start, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_dr_code", dr_code, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // end marker at entry 0
    set_entry(0, 16'h0, 16'h0, 16'h0, 16'hFF00);
    got_q.delete();
    build_model(9'h0);
    pulse_start(9'h0);
    n = 1;
    chk("endmark_addr", table_addr, 10'h003);
    while (!done && n < 8) begin
      @(negedge clk);
      n++;
      chk("endmark_addr", table_addr, 10'h003);
    end
    chk("endmark_done", done, 1);
    chk("endmark_latency", n <= 4, 1);
    repeat (3) @(negedge clk);
    chk("endmark_addr_held", table_addr, 10'h003);
    chk("endmark_done_held", done, 1);
    chk("endmark_draws", got_q.size(), 0);

    // single 1x1 sprite
    clear_tbl();
    set_entry(0, 16'h0040, 16'h0020, 16'h1230, 16'h0000);
    set_entry(1, 16'h0, 16'h0, 16'h0, 16'hFF00);
    run_scan("single", 9'h025, 100);
    chk("single_count", got_q.size(), 1);
    chk("single_fields", got_q[0], {16'h1230, 9'h040, 4'd5, 16'h0000});

    // 2x2 hflip sprite crossing x wrap, low nibble wrapping
    set_entry(0, 16'h01F8, 16'h0020, 16'h123E, 16'h1120);
    run_scan("hflip", 9'h031, 100);
    chk("hflip_count", got_q.size(), 2);
    chk("hflip_first", got_q[0], {16'h124F, 9'h1F8, 4'd1, 16'h1120});
    chk("hflip_second", got_q[1], {16'h124E, 9'h008, 4'd1, 16'h1120});

    // vflip with y wrap
    set_entry(0, 16'h0010, 16'h01F8, 16'h0500, 16'h0040);
    run_scan("vflip", 9'h003, 100);
    chk("vflip_count", got_q.size(), 1);
    chk("vflip_fields", got_q[0], {16'h0500, 9'h010, 4'd4, 16'h0040});
    run_scan("vflip_miss", 9'h010, 100);
    chk("vflip_miss_count", got_q.size(), 0);

    // drawer busy, then restart on top of the pending draw
    set_entry(0, 16'h0040, 16'h0020, 16'h1230, 16'h0000);
    force_busy = 1'b1;
    exp_q.delete();
    got_q.delete();
    pulse_start(9'h025);
    repeat (10) begin
      @(negedge clk);
      chk("busy_hold", dr_start, 0);
    end
    chk("busy_addr_code_word", table_addr, 10'h002);
    build_model(9'h025);
    pulse_start(9'h025);
    chk("abort_addr", table_addr, 10'h003);
    chk("abort_done", done, 0);
    repeat (8) @(negedge clk);
    force_busy = 1'b0;
    wait_done("abort", 200);
    chk("abort_pending", exp_q.size(), 0);
    chk("abort_count", got_q.size(), 1);

    // 40 single-tile hits on one line
    clear_tbl();
    for (int i = 0; i < 40; i++)
      set_entry(i, 16'(i * 8), 16'h0, 16'(i * 16), 16'h0000);
    set_entry(40, 16'h0, 16'h0, 16'h0, 16'hFF00);
    busy_len = 2;
    run_scan("many", 9'h005, 3000);
`ifdef JTCPS1_OBJ_LIMIT_EN
    chk("many_count", got_q.size(), 32);
    chk("many_overflow_lit", overflow, 1);
`else
    chk("many_count", got_q.size(), 40);
    chk("many_overflow_lit", overflow, 0);
`endif

    // full table, no end marker, mixed sizes and flips
    clear_tbl();
    for (int i = 0; i < 256; i++)
      set_entry(i, 16'((i * 37) & 511), 16'((i * 7) & 511), 16'((i * 16'h111) & 16'hFFFF),
                16'(((i % 4) << 12) | ((i % 3) << 8) | (((i >> 1) & 1) << 6)
                    | ((i & 1) << 5) | (i & 31)));
    busy_len = 1;
    run_scan("full", 9'h040, 30000);
    chk("full_addr_last", table_addr, 10'h3FE);

    // async reset in the middle of an emit
    clear_tbl();
    set_entry(0, 16'h01F8, 16'h0020, 16'h123E, 16'h1120);
    force_busy = 1'b1;
    exp_q.delete();
    pulse_start(9'h031);
    repeat (12) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midreset_dr_start", dr_start, 0);
    chk("midreset_addr", table_addr, 0);
    chk("midreset_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    force_busy = 1'b0;
    repeat (20) @(negedge clk);
    chk("midreset_idle_done", done, 0);
    chk("midreset_idle_addr", table_addr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
